rotary_param_ctrl: RTL and testbench



---
 rtl/rotary_param_ctrl.sv | 200 ++++++++++++++++++++
 tb/tb_rotary_param_ctrl.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rotary_param_ctrl.sv
// Shares one debounced rotary encoder and push-button across NUM_PARAMS parameter registers.
// Optional macro ROTARY_PARAM_ACCEL_EN: larger steps while the encoder is turned quickly in one direction.
module rotary_param_ctrl #(
    parameter int NUM_PARAMS   = 4,
    parameter int WIDTH        = 8,
    parameter int TIMEOUT      = 50000000,
    parameter int ACCEL_WINDOW = 2000000,
    parameter int ACCEL_STEP   = 4,
    localparam int IW = (NUM_PARAMS > 2) ? $clog2(NUM_PARAMS) : 1,
    localparam int TW = $clog2(TIMEOUT + 1)
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        rot_cw,
    input  logic                        rot_ccw,
    input  logic                        btn,
    output logic [NUM_PARAMS*WIDTH-1:0] params,
    output logic [IW-1:0]               sel_idx,
    output logic                        editing,
    output logic [WIDTH-1:0]            edit_value,
    output logic                        wr_pulse,
    output logic [IW-1:0]               wr_idx,
    output logic [WIDTH-1:0]            wr_data
);

    typedef enum logic [1:0] {
        ST_SELECT = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic             cw_hist_q, ccw_hist_q, btn_hist_q;
    logic [IW-1:0]    sel_q, sel_d;
    logic [WIDTH-1:0] shadow_q, shadow_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [IW-1:0]    wr_idx_q;
    logic [WIDTH-1:0] wr_data_q;
    logic [WIDTH-1:0] param_vals [NUM_PARAMS];

    logic             cw_ev, ccw_ev, btn_ev;
    logic             cw_only, ccw_only, rot_ev;
    logic             edit_enter, edit_commit, edit_step, timed_out;
    logic [WIDTH:0]   step, shadow_up, shadow_dn;

    assign cw_ev    = rot_cw & ~cw_hist_q;
    assign ccw_ev   = rot_ccw & ~ccw_hist_q;
    assign btn_ev   = btn & ~btn_hist_q;
    // Opposing events in the same cycle cancel each other out.
    assign cw_only  = cw_ev & ~ccw_ev;
    assign ccw_only = ccw_ev & ~cw_ev;
    assign rot_ev   = cw_only | ccw_only;

    assign edit_enter  = (state_q == ST_SELECT) && btn_ev;
    assign edit_commit = (state_q == ST_EDIT) && btn_ev;
    assign edit_step   = (state_q == ST_EDIT) && !btn_ev && rot_ev;
    assign timed_out   = (state_q == ST_EDIT) && !btn_ev && !rot_ev &&
                         (timer_q == TW'(TIMEOUT - 1));

    assign shadow_up = {1'b0, shadow_q} + step;
    assign shadow_dn = {1'b0, shadow_q} - step;

`ifdef ROTARY_PARAM_ACCEL_EN
    localparam int GW = $clog2(ACCEL_WINDOW + 1);

    logic [GW-1:0] gap_q;
    logic          dir_vld_q, dir_cw_q;

    always_comb begin
        step = {{WIDTH{1'b0}}, 1'b1};
        if (dir_vld_q && (dir_cw_q == cw_only) && (gap_q < GW'(ACCEL_WINDOW))) begin
            step = (WIDTH + 1)'(ACCEL_STEP);
        end
    end

    // Gap counter saturates so an idle encoder never wraps back into the fast window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            gap_q     <= '0;
            dir_vld_q <= 1'b0;
            dir_cw_q  <= 1'b0;
        end else begin
            if (edit_step) begin
                gap_q     <= '0;
                dir_vld_q <= 1'b1;
                dir_cw_q  <= cw_only;
            end else if (gap_q != GW'(ACCEL_WINDOW)) begin
                gap_q <= gap_q + 1'b1;
            end
            if (edit_enter) begin
                dir_vld_q <= 1'b0;
            end
        end
    end
`else
    assign step = {{WIDTH{1'b0}}, 1'b1};
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_SELECT;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_SELECT: if (btn_ev) state_d = ST_EDIT;
            ST_EDIT: begin
                if (btn_ev) begin
                    state_d = ST_COMMIT;
                end else if (timed_out) begin
                    state_d = ST_SELECT;
                end
            end
            ST_COMMIT: state_d = ST_SELECT;
            default:   state_d = ST_SELECT;
        endcase
    end

    always_comb begin
        editing    = (state_q == ST_EDIT);
        wr_pulse   = (state_q == ST_COMMIT);
        edit_value = (state_q == ST_EDIT) ? shadow_q : param_vals[sel_q];
    end

    // Button wins over a rotary event in the same cycle in both modes.
    always_comb begin
        sel_d    = sel_q;
        shadow_d = shadow_q;
        timer_d  = timer_q;
        if (edit_enter) begin
            shadow_d = param_vals[sel_q];
            timer_d  = '0;
        end else if ((state_q == ST_SELECT) && cw_only) begin
            sel_d = (sel_q == IW'(NUM_PARAMS - 1)) ? '0 : sel_q + 1'b1;
        end else if ((state_q == ST_SELECT) && ccw_only) begin
            sel_d = (sel_q == '0) ? IW'(NUM_PARAMS - 1) : sel_q - 1'b1;
        end
        if (edit_step) begin
            timer_d = '0;
            if (cw_only) begin
                shadow_d = shadow_up[WIDTH] ? '1 : shadow_up[WIDTH-1:0];
            end else begin
                shadow_d = shadow_dn[WIDTH] ? '0 : shadow_dn[WIDTH-1:0];
            end
        end else if ((state_q == ST_EDIT) && !btn_ev) begin
            timer_d = timed_out ? '0 : timer_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cw_hist_q  <= 1'b0;
            ccw_hist_q <= 1'b0;
            btn_hist_q <= 1'b0;
            sel_q      <= '0;
            shadow_q   <= '0;
            timer_q    <= '0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
        end else begin
            cw_hist_q  <= rot_cw;
            ccw_hist_q <= rot_ccw;
            btn_hist_q <= btn;
            sel_q      <= sel_d;
            shadow_q   <= shadow_d;
            timer_q    <= timer_d;
            if (edit_commit) begin
                wr_idx_q  <= sel_q;
                wr_data_q <= shadow_q;
            end
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
            logic [WIDTH-1:0] param_q;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    param_q <= '0;
                end else if (edit_commit && (sel_q == IW'(gi))) begin
                    param_q <= shadow_q;
                end
            end

            assign param_vals[gi]            = param_q;
            assign params[gi*WIDTH +: WIDTH] = param_q;
        end
    endgenerate

    assign sel_idx = sel_q;
    assign wr_idx  = wr_idx_q;
    assign wr_data = wr_data_q;

endmodule

// File: tb/tb_rotary_param_ctrl.sv
// Randomised and directed bench for rotary_param_ctrl against a cycle-level behavioural model.
// Build with ROTARY_PARAM_ACCEL_EN defined to exercise the acceleration variant.
module tb_rotary_param_ctrl;

    localparam int NP   = 4;
    localparam int W    = 8;
    localparam int TO   = 16;
    localparam int AW   = 10;
    localparam int AS   = 4;
    localparam int IW   = 2;
    localparam int MAXV = 255;
    localparam int SLOW = 11;

    logic            clk = 1'b0;
    logic            rst;
    logic            rot_cw, rot_ccw, btn;
    logic [NP*W-1:0] params;
    logic [IW-1:0]   sel_idx, wr_idx;
    logic            editing, wr_pulse;
    logic [W-1:0]    edit_value, wr_data;

    int checks = 0;
    int errors = 0;
    int wr_seen = 0;
    int base;

    int m_params [NP];
    int m_sel, m_mode, m_shadow, m_idle, m_wr_idx, m_wr_data, m_gap, m_last_dir;
    bit m_hcw, m_hccw, m_hbtn;

    always #5 clk = ~clk;

    rotary_param_ctrl #(
        .NUM_PARAMS  (NP),
        .WIDTH       (W),
        .TIMEOUT     (TO),
        .ACCEL_WINDOW(AW),
        .ACCEL_STEP  (AS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rot_cw    (rot_cw),
        .rot_ccw   (rot_ccw),
        .btn       (btn),
        .params    (params),
        .sel_idx   (sel_idx),
        .editing   (editing),
        .edit_value(edit_value),
        .wr_pulse  (wr_pulse),
        .wr_idx    (wr_idx),
        .wr_data   (wr_data)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Mode: 0 = choosing a register, 1 = editing, 2 = committing.
    task automatic model_reset();
        for (int i = 0; i < NP; i++) m_params[i] = 0;
        m_sel = 0; m_mode = 0; m_shadow = 0; m_idle = 0;
        m_wr_idx = 0; m_wr_data = 0; m_gap = 0; m_last_dir = 0;
        m_hcw = 0; m_hccw = 0; m_hbtn = 0;
    endtask

    task automatic model_step();
        bit ce, cce, be, stepped;
        int dir, stp;
        ce  = rot_cw && !m_hcw;
        cce = rot_ccw && !m_hccw;
        be  = btn && !m_hbtn;
        m_hcw = rot_cw; m_hccw = rot_ccw; m_hbtn = btn;
        dir = 0;
        if (ce && !cce) dir = 1;
        else if (cce && !ce) dir = -1;
        stepped = 0;
        case (m_mode)
            0: begin
                if (be) begin
                    m_mode = 1; m_shadow = m_params[m_sel]; m_idle = 0; m_last_dir = 0;
                end else if (dir != 0) begin
                    m_sel = (m_sel + dir + NP) % NP;
                end
            end
            1: begin
                if (be) begin
                    m_mode = 2; m_params[m_sel] = m_shadow;
                    m_wr_idx = m_sel; m_wr_data = m_shadow;
                end else if (dir != 0) begin
                    stp = 1;
`ifdef ROTARY_PARAM_ACCEL_EN
                    if (m_last_dir == dir && m_gap < AW) stp = AS;
`endif
                    m_shadow = m_shadow + dir * stp;
                    if (m_shadow > MAXV) m_shadow = MAXV;
                    if (m_shadow < 0) m_shadow = 0;
                    m_idle = 0; m_last_dir = dir; m_gap = 0; stepped = 1;
                end else begin
                    m_idle++;
                    if (m_idle == TO) m_mode = 0;
                end
            end
            default: m_mode = 0;
        endcase
        if (!stepped && m_gap < AW) m_gap++;
    endtask

    task automatic compare_all();
        logic [NP*W-1:0] exp_p;
        for (int i = 0; i < NP; i++) exp_p[i*W +: W] = W'(m_params[i]);
        check_val("params", params, exp_p);
        check_val("sel_idx", sel_idx, m_sel);
        check_val("editing", editing, m_mode == 1);
        check_val("wr_pulse", wr_pulse, m_mode == 2);
        check_val("edit_value", edit_value, (m_mode == 1) ? m_shadow : m_params[m_sel]);
        check_val("wr_idx", wr_idx, m_wr_idx);
        check_val("wr_data", wr_data, m_wr_data);
        if (wr_pulse === 1'b1) wr_seen++;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        @(negedge clk);
        compare_all();
    endtask

    // which: 0 cw, 1 ccw, 2 btn, 3 cw+ccw, 4 btn+cw, 5 idle
    task automatic pulse(input int which, input int hi, input int lo);
        for (int i = 0; i < hi; i++) begin
            rot_cw  = (which == 0 || which == 3 || which == 4);
            rot_ccw = (which == 1 || which == 3);
            btn     = (which == 2 || which == 4);
            tick();
        end
        rot_cw = 1'b0; rot_ccw = 1'b0; btn = 1'b0;
        for (int i = 0; i < lo; i++) tick();
        $display("op=%0d hi=%0d lo=%0d sel=%0d editing=%0b edit_value=%0d params=%h",
                 which, hi, lo, sel_idx, editing, edit_value, params);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete within the time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; rot_cw = 1'b0; rot_ccw = 1'b0; btn = 1'b0;
        model_reset();
        repeat (2) tick();
        rst = 1'b0;
        check_val("rst_params", params, 0);
        check_val("rst_sel", sel_idx, 0);
        check_val("rst_editing", editing, 0);
        check_val("rst_wr_pulse", wr_pulse, 0);

        // Selection wrap in both directions.
        pulse(1, 1, 1);
        check_val("ccw_wrap", sel_idx, 3);
        pulse(0, 1, 1);
        repeat (5) pulse(0, 1, 1);
        check_val("cw5_sel", sel_idx, 1);

        // Edit and commit register 2.
        pulse(0, 1, 1);
        base = wr_seen;
        pulse(2, 1, 1);
        repeat (3) pulse(0, 1, SLOW);
        check_val("edit3", edit_value, 3);
        pulse(2, 1, 2);
        check_val("commit_pulses", wr_seen - base, 1);
        check_val("commit_idx", wr_idx, 2);
        check_val("commit_data", wr_data, 3);
        check_val("commit_params", params, 32'h0003_0000);
        check_val("commit_editing", editing, 0);

        // Saturation high then low.
        pulse(2, 1, 1);
        repeat (251) pulse(0, 1, SLOW);
        pulse(2, 1, 2);
        check_val("p2_254", params[2*W +: W], 254);
        pulse(2, 1, 1);
        repeat (3) pulse(0, 1, SLOW);
        check_val("sat_hi_edit", edit_value, 255);
        pulse(2, 1, 2);
        check_val("sat_hi_commit", params[2*W +: W], 255);
        pulse(0, 1, 1);
        pulse(2, 1, 1);
        repeat (2) pulse(1, 1, SLOW);
        check_val("sat_lo_edit", edit_value, 0);
        pulse(2, 1, 2);
        check_val("sat_lo_data", wr_data, 0);
        check_val("sat_lo_idx", wr_idx, 3);

        // Inactivity abandons the edit without writing.
        base = wr_seen;
        pulse(2, 1, 1);
        repeat (2) pulse(0, 1, SLOW);
        check_val("to_edit", edit_value, 2);
        pulse(5, TO, 0);
        check_val("to_editing", editing, 0);
        check_val("to_no_write", wr_seen - base, 0);
        check_val("to_param", params[3*W +: W], 0);
        check_val("to_edit_value", edit_value, 0);

        // Simultaneous events.
        pulse(3, 1, 1);
        check_val("sim_sel", sel_idx, 3);
        pulse(2, 1, 1);
        repeat (5) pulse(0, 1, SLOW);
        pulse(3, 1, 1);
        check_val("sim_edit", edit_value, 5);
        pulse(4, 1, 2);
        check_val("btn_cw_param", params[3*W +: W], 5);
        check_val("btn_cw_data", wr_data, 5);

        // Fast turning versus slow turning.
        pulse(0, 1, 1);
        pulse(2, 1, 1);
        repeat (3) pulse(0, 1, 3);
`ifdef ROTARY_PARAM_ACCEL_EN
        check_val("accel_fast", edit_value, 9);
`else
        check_val("accel_fast", edit_value, 3);
`endif
        pulse(5, 10, 0);
        pulse(0, 1, 1);
`ifdef ROTARY_PARAM_ACCEL_EN
        check_val("accel_slow", edit_value, 10);
`else
        check_val("accel_slow", edit_value, 4);
`endif
        pulse(2, 1, 2);

        // Asynchronous reset in the middle of an edit.
        pulse(0, 1, 1);
        pulse(2, 1, 1);
        repeat (2) pulse(0, 1, SLOW);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        check_val("arst_params", params, 0);
        check_val("arst_sel", sel_idx, 0);
        check_val("arst_editing", editing, 0);
        check_val("arst_edit_value", edit_value, 0);
        tick();
        rst = 1'b0;
        tick();

        for (int n = 0; n < 300; n++) begin
            int which;
            which = int'($urandom_range(0, 4));
            if (which == 4) pulse(5, int'($urandom_range(1, 20)), 0);
            else pulse(which, int'($urandom_range(1, 2)), int'($urandom_range(0, 14)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
